ysyx_24100012_regfile_sb: RTL and testbench

//   Parametrised GPR file for the next-gen NPC core: N_RD combinational read ports, N_WR write

---
 rtl/ysyx_24100012_regfile_sb.sv | 103 ++++++++++
 tb/tb_ysyx_24100012_regfile_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_regfile_sb.sv
// GPR file with N_RD combinational read ports, N_WR prioritised write ports, optional
// same-cycle write->read bypass and a per-register busy scoreboard for RAW detection.
module ysyx_24100012_regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_LEN  = 5,
    parameter int N_REG      = 32,
    parameter int N_RD       = 2,
    parameter int N_WR       = 1,
    parameter int BYPASS     = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_WR-1:0]                 wen_i,
    input  logic [N_WR*INDEX_LEN-1:0]       waddr_i,
    input  logic [N_WR*DATA_WIDTH-1:0]      wdata_i,
    input  logic [N_RD*INDEX_LEN-1:0]       raddr_i,
    output logic [N_RD*DATA_WIDTH-1:0]      rdata_o,
    output logic [N_RD-1:0]                 rbusy_o,
    input  logic                            iss_valid_i,
    input  logic [INDEX_LEN-1:0]            iss_rd_i,
    output logic [N_REG-1:0]                busy_vec_o
);

    logic [N_REG-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [N_REG-1:0]                 busy_q, busy_d;
    logic [N_REG-1:0]                 wr_hit;
    logic [N_REG-1:0][DATA_WIDTH-1:0] wr_data;

    // Ascending port scan so the highest-numbered matching port wins.
    always_comb begin : write_decode
        wr_hit  = '0;
        wr_data = '0;
        for (int i = 0; i < N_REG; i++) begin
            for (int p = 0; p < N_WR; p++) begin
                if (wen_i[p] && waddr_i[p*INDEX_LEN +: INDEX_LEN] == INDEX_LEN'(i)) begin
                    wr_hit[i]  = 1'b1;
                    wr_data[i] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Issue beats write-back clear: a new producer keeps the register busy.
    always_comb begin : next_state
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < N_REG; i++) begin
            if (wr_hit[i]) regs_d[i] = wr_data[i];
            if (iss_valid_i && iss_rd_i == INDEX_LEN'(i)) busy_d[i] = 1'b1;
            else if (wr_hit[i])                           busy_d[i] = 1'b0;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

    for (genvar r = 0; r < N_RD; r++) begin : g_rd
        logic [INDEX_LEN-1:0]  ra;
        logic                  in_range;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra       = raddr_i[r*INDEX_LEN +: INDEX_LEN];
        assign in_range = (ra != '0) && (int'(ra) < N_REG);

        // Explicit compare mux so out-of-range indices can never alias a register.
        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (in_range) begin
                for (int i = 0; i < N_REG; i++) begin
                    if (ra == INDEX_LEN'(i)) begin
                        rd = regs_q[i];
                        rb = busy_q[i];
                    end
                end
                if (BYPASS != 0) begin
                    for (int p = 0; p < N_WR; p++) begin
                        if (wen_i[p] && waddr_i[p*INDEX_LEN +: INDEX_LEN] == ra) begin
                            rd = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                            rb = 1'b0;
                        end
                    end
                end
            end
        end

        assign rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign rbusy_o[r]                          = rb;
    end

endmodule

// File: tb/tb_ysyx_24100012_regfile_sb.sv
// Directed bench: A = 2 write ports with bypass, B = 1 write port, no bypass, 16 registers.
// Expected values are queued when stimulus is driven and popped when outputs are sampled.
module tb_ysyx_24100012_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  a_wen;
    logic [9:0]  a_waddr;
    logic [63:0] a_wdata;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic        a_iss_valid;
    logic [4:0]  a_iss_rd;
    logic [31:0] a_busy;

    logic [0:0]  b_wen;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [9:0]  b_raddr;
    logic [63:0] b_rdata;
    logic [1:0]  b_rbusy;
    logic        b_iss_valid;
    logic [4:0]  b_iss_rd;
    logic [15:0] b_busy;

    ysyx_24100012_regfile_sb #(.N_WR(2), .BYPASS(1)) u_a (
        .clk_i(clk), .rst_i(rst), .wen_i(a_wen), .waddr_i(a_waddr), .wdata_i(a_wdata),
        .raddr_i(a_raddr), .rdata_o(a_rdata), .rbusy_o(a_rbusy),
        .iss_valid_i(a_iss_valid), .iss_rd_i(a_iss_rd), .busy_vec_o(a_busy)
    );

    ysyx_24100012_regfile_sb #(.N_WR(1), .BYPASS(0), .N_REG(16), .INDEX_LEN(5)) u_b (
        .clk_i(clk), .rst_i(rst), .wen_i(b_wen), .waddr_i(b_waddr), .wdata_i(b_wdata),
        .raddr_i(b_raddr), .rdata_o(b_rdata), .rbusy_o(b_rbusy),
        .iss_valid_i(b_iss_valid), .iss_rd_i(b_iss_rd), .busy_vec_o(b_busy)
    );

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_wen = '0; a_waddr = '0; a_wdata = '0; a_iss_valid = 1'b0; a_iss_rd = '0;
        b_wen = '0; b_waddr = '0; b_wdata = '0; b_iss_valid = 1'b0; b_iss_rd = '0;
    endtask

    initial begin
        idle();
        a_raddr = '0;
        b_raddr = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Random traffic, then reset with traffic still applied.
        for (int c = 0; c < 5; c++) begin
            a_wen = 2'b11; a_waddr = 10'($urandom); a_wdata = {$urandom, $urandom};
            a_iss_valid = 1'b1; a_iss_rd = 5'($urandom_range(1, 31));
            b_wen = 1'b1; b_waddr = 5'($urandom); b_wdata = $urandom;
            b_iss_valid = 1'b1; b_iss_rd = 5'($urandom_range(1, 15));
            if (c == 4) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        idle();
        #1;
        push(32'h0); chk("rst_a_busy", a_busy);
        push(32'h0); chk("rst_b_busy", {16'h0, b_busy});
        for (int i = 1; i < 32; i++) begin
            a_raddr = {5'd0, 5'(i)};
            b_raddr = {5'(i), 5'(i)};
            #1;
            push(32'h0); chk("rst_a_rdata", a_rdata[31:0]);
            push(32'h0); chk("rst_b_rdata", b_rdata[63:32]);
            push(32'h0); chk("rst_rbusy", {30'h0, b_rbusy[1], a_rbusy[0]});
        end

        // Same-cycle bypass vs registered read.
        a_wen = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'h0, 32'h0BAD0001};
        b_wen = 1'b1;  b_waddr = 5'd5;         b_wdata = 32'h0BAD0001;
        tick();
        a_wdata = {32'h0, 32'hDEADBEEF};
        b_wdata = 32'hDEADBEEF;
        a_raddr = {5'd0, 5'd5};
        b_raddr = {5'd0, 5'd5};
        #1;
        push(32'hDEADBEEF); chk("byp_a_same", a_rdata[31:0]);
        push(32'h0BAD0001); chk("nobyp_b_same", b_rdata[31:0]);
        tick();
        idle();
        #1;
        push(32'hDEADBEEF); chk("byp_a_next", a_rdata[31:0]);
        push(32'hDEADBEEF); chk("nobyp_b_next", b_rdata[31:0]);
        push(32'h0);        chk("legal_write_not_busy", {16'h0, b_busy});

        // x0 is never written, bypassed or marked busy.
        a_wen = 2'b01; a_waddr = '0; a_wdata = {32'h0, 32'h1234};
        a_iss_valid = 1'b1; a_iss_rd = 5'd0; a_raddr = '0;
        #1;
        push(32'h0); chk("x0_same", a_rdata[31:0]);
        tick();
        idle();
        #1;
        push(32'h0); chk("x0_next", a_rdata[31:0]);
        push(32'h0); chk("x0_busy", a_busy);

        // Write-port priority on address clash.
        a_wen = 2'b11; a_waddr = {5'd7, 5'd7}; a_wdata = {32'h22, 32'h11};
        a_raddr = {5'd7, 5'd0};
        #1;
        push(32'h22); chk("clash_byp", a_rdata[63:32]);
        tick();
        idle();
        #1;
        push(32'h22); chk("clash_next", a_rdata[63:32]);

        // Scoreboard on A: set, set-beats-clear, clear.
        a_iss_valid = 1'b1; a_iss_rd = 5'd3;
        tick();
        idle();
        a_raddr = {5'd0, 5'd3};
        #1;
        push(32'h8); chk("sb_set_vec", a_busy);
        push(32'h1); chk("sb_set_rbusy", {31'h0, a_rbusy[0]});
        a_wen = 2'b01; a_waddr = {5'd0, 5'd3}; a_wdata = {32'h0, 32'h33};
        a_iss_valid = 1'b1; a_iss_rd = 5'd3;
        #1;
        push(32'h0);  chk("sb_byp_rbusy", {31'h0, a_rbusy[0]});
        push(32'h33); chk("sb_byp_rdata", a_rdata[31:0]);
        tick();
        idle();
        #1;
        push(32'h8);  chk("sb_setclr_vec", a_busy);
        push(32'h1);  chk("sb_setclr_rbusy", {31'h0, a_rbusy[0]});
        push(32'h33); chk("sb_setclr_rdata", a_rdata[31:0]);
        a_wen = 2'b10; a_waddr = {5'd3, 5'd0}; a_wdata = {32'h34, 32'h0};
        tick();
        idle();
        #1;
        push(32'h0);  chk("sb_clr_vec", a_busy);
        push(32'h34); chk("sb_clr_rdata", a_rdata[31:0]);

        // Scoreboard on B: no bypass, busy stays visible during write-back.
        b_iss_valid = 1'b1; b_iss_rd = 5'd3;
        tick();
        idle();
        b_raddr = {5'd0, 5'd3};
        b_wen = 1'b1; b_waddr = 5'd3; b_wdata = 32'h55;
        #1;
        push(32'h8); chk("b_sb_vec", {16'h0, b_busy});
        push(32'h1); chk("b_sb_rbusy", {31'h0, b_rbusy[0]});
        push(32'h0); chk("b_sb_old", b_rdata[31:0]);
        tick();
        idle();
        #1;
        push(32'h0);  chk("b_sb_clr", {16'h0, b_busy});
        push(32'h55); chk("b_sb_rdata", b_rdata[31:0]);

        // Out-of-range index on 16-register instance must not alias x4.
        b_wen = 1'b1; b_waddr = 5'd4; b_wdata = 32'h44;
        tick();
        b_waddr = 5'd20; b_wdata = 32'hFF;
        b_iss_valid = 1'b1; b_iss_rd = 5'd20;
        b_raddr = {5'd4, 5'd20};
        #1;
        push(32'h0); chk("oor_same_rdata", b_rdata[31:0]);
        tick();
        idle();
        #1;
        push(32'h0);  chk("oor_rdata", b_rdata[31:0]);
        push(32'h0);  chk("oor_rbusy", {31'h0, b_rbusy[0]});
        push(32'h44); chk("oor_x4", b_rdata[63:32]);
        push(32'h0);  chk("oor_busy", {16'h0, b_busy});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
